// File: rtl/ser_160.sv
// Oversampled LSB-first serializer: 8-bit words through a small FIFO, each bit held OVERSAMPLE clocks.
// Optional SER_IDLE_PATTERN_EN: after the first enable, frames never stop and gaps are filled with IDLE_WORD.
module ser_160 #(
  parameter int FIFO_DEPTH = 4,
  parameter int OVERSAMPLE = 4,
`ifdef SER_IDLE_PATTERN_EN
  parameter logic [7:0] IDLE_WORD = 8'hBC,
`endif
  parameter int LVL_W = $clog2(FIFO_DEPTH + 1)
) (
  input  logic             clock_160,
  input  logic             reset,
  input  logic             enable,
  input  logic [7:0]       data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             data_out,
  output logic             word_start,
  output logic             busy,
  output logic [LVL_W-1:0] fifo_level
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = $clog2(OVERSAMPLE);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  state_t           r_state;
  logic [PW-1:0]    r_phase;
  logic [2:0]       r_bit;
  logic [7:0]       r_shift;
  logic             r_data_out;
  logic             r_word_start;
  logic             r_busy;
  logic [7:0]       r_mem [FIFO_DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [LVL_W-1:0] r_level;

  logic       w_full;
  logic       w_push;
  logic       w_pop;
  logic       w_load;
  logic       w_last_phase;
  logic       w_frame_end;
  logic [7:0] w_load_word;

  assign w_full       = (r_level == LVL_W'(FIFO_DEPTH));
  assign w_push       = data_valid && !w_full;
  assign w_last_phase = (r_phase == PW'(OVERSAMPLE - 1));
  assign w_frame_end  = (r_state == S_SHIFT) && w_last_phase && (r_bit == 3'd7);
  assign w_pop        = enable && (r_level != '0) && ((r_state == S_IDLE) || w_frame_end);

`ifdef SER_IDLE_PATTERN_EN
  // Once running, every frame boundary reloads: a data word if one may be popped, else the filler.
  assign w_load      = (r_state == S_IDLE) ? enable : w_frame_end;
  assign w_load_word = w_pop ? r_mem[r_rptr] : IDLE_WORD;
`else
  assign w_load      = w_pop;
  assign w_load_word = r_mem[r_rptr];
`endif

  assign data_ready = !w_full;
  assign data_out   = r_data_out;
  assign word_start = r_word_start;
  assign busy       = r_busy;
  assign fifo_level = r_level;

  always_ff @(posedge clock_160) begin
    if (w_push) r_mem[r_wptr] <= data_in;
  end

  always_ff @(posedge clock_160 or negedge reset) begin
    if (!reset) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_level <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + LVL_W'(1);
        2'b01:   r_level <= r_level - LVL_W'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  // r_shift[0] is always the bit currently on the line.
  always_ff @(posedge clock_160) begin
    if (w_load)
      r_shift <= w_load_word;
    else if ((r_state == S_SHIFT) && w_last_phase)
      r_shift <= r_shift >> 1;
  end

  always_ff @(posedge clock_160 or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_phase      <= '0;
      r_bit        <= '0;
      r_data_out   <= 1'b0;
      r_word_start <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      r_word_start <= 1'b0;
      if (w_load) begin
        r_state      <= S_SHIFT;
        r_phase      <= '0;
        r_bit        <= '0;
        r_data_out   <= w_load_word[0];
        r_word_start <= w_pop;
        r_busy       <= 1'b1;
      end else if (r_state == S_SHIFT) begin
        if (w_frame_end) begin
          r_state    <= S_IDLE;
          r_phase    <= '0;
          r_bit      <= '0;
          r_data_out <= 1'b0;
          r_busy     <= 1'b0;
        end else begin
          r_phase <= r_phase + PW'(1);
          if (w_last_phase) begin
            r_bit      <= r_bit + 3'd1;
            r_data_out <= r_shift[1];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_ser_160.sv
// Bench for ser_160 (default build): directed scenarios plus random traffic against a frame-level model
// and a phase-3 sampling deserializer that must recover every accepted word in order.
module tb_ser_160;

  localparam int OS = 4;
  localparam int FRAME = 8 * OS;

  logic       clock_160 = 1'b0;
  logic       reset;
  logic       enable;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       data_out;
  logic       word_start;
  logic       busy;
  logic [2:0] fifo_level;

  int errors = 0;
  int checks = 0;

  // Frame-level model: pending words, the word on the line and how far into its frame we are.
  logic [7:0] m_q[$];
  logic [7:0] m_word;
  bit         m_active;
  int         m_idx;

  // Loopback receiver state and the words it is owed.
  logic [7:0] lb_q[$];
  bit         lb_active;
  int         lb_cnt;
  logic [7:0] lb_sh;

  ser_160 #(.FIFO_DEPTH(4), .OVERSAMPLE(OS)) dut (
    .clock_160 (clock_160),
    .reset     (reset),
    .enable    (enable),
    .data_in   (data_in),
    .data_valid(data_valid),
    .data_ready(data_ready),
    .data_out  (data_out),
    .word_start(word_start),
    .busy      (busy),
    .fifo_level(fifo_level)
  );

  always #5 clock_160 = ~clock_160;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic en, input logic v, input logic [7:0] d);
    bit push, pop;
    push = v && (m_q.size() < 4);
    pop  = en && (m_q.size() > 0) && (!m_active || m_idx == FRAME - 1);
    if (m_active) begin
      m_idx++;
      if (m_idx == FRAME) m_active = 0;
    end
    if (pop) begin
      m_word   = m_q.pop_front();
      m_active = 1;
      m_idx    = 0;
    end
    if (push) begin
      m_q.push_back(d);
      lb_q.push_back(d);
    end
  endtask

  task automatic check_outputs();
    logic exp_bit;
    exp_bit = m_active ? m_word[m_idx / OS] : 1'b0;
    check("data_out",   {7'd0, data_out},   {7'd0, exp_bit});
    check("busy",       {7'd0, busy},       {7'd0, m_active});
    check("word_start", {7'd0, word_start}, {7'd0, (m_active && m_idx == 0)});
    check("fifo_level", {5'd0, fifo_level}, 8'(m_q.size()));
    check("data_ready", {7'd0, data_ready}, {7'd0, (m_q.size() < 4)});
  endtask

  task automatic deser();
    if (word_start) begin
      lb_active = 1;
      lb_cnt    = 0;
    end else if (lb_active) begin
      lb_cnt++;
    end
    if (lb_active && (lb_cnt % OS) == OS - 1) lb_sh = {data_out, lb_sh[7:1]};
    if (lb_active && lb_cnt == FRAME - 1) begin
      lb_active = 0;
      check("lb_owed", {7'd0, (lb_q.size() > 0)}, 8'd1);
      if (lb_q.size() > 0) check("loopback", lb_sh, lb_q.pop_front());
    end
  endtask

  task automatic step(input logic en, input logic v, input logic [7:0] d);
    enable     = en;
    data_valid = v;
    data_in    = d;
    @(posedge clock_160);
    model_edge(en, v, d);
    #1;
    check_outputs();
    deser();
  endtask

  task automatic idle_steps(input logic en, input int n);
    for (int i = 0; i < n; i++) step(en, 1'b0, 8'h00);
  endtask

  task automatic model_reset();
    m_q.delete();
    lb_q.delete();
    m_active  = 0;
    m_idx     = 0;
    lb_active = 0;
  endtask

  initial begin
    logic en_r;
    model_reset();
    enable = 0; data_valid = 0; data_in = 0;
    reset = 0;
    #12;
    check("rst_data_out",   {7'd0, data_out},   8'd0);
    check("rst_busy",       {7'd0, busy},       8'd0);
    check("rst_word_start", {7'd0, word_start}, 8'd0);
    check("rst_level",      {5'd0, fifo_level}, 8'd0);
    check("rst_ready",      {7'd0, data_ready}, 8'd1);
    @(negedge clock_160);
    reset = 1;

    // Single word 8'hA5 into an empty block with enable high.
    step(1'b1, 1'b1, 8'hA5);
    idle_steps(1'b1, 40);

    // Burst of 6 with enable low: only 01..04 get in.
    for (int i = 1; i <= 6; i++) step(1'b0, 1'b1, 8'(i));
    check("burst_level", {5'd0, fifo_level}, 8'd4);
    check("burst_ready", {7'd0, data_ready}, 8'd0);
    idle_steps(1'b1, 140);

    // Enable dropped 10 cycles into 8'hFF with 8'h0F queued.
    step(1'b0, 1'b1, 8'hFF);
    step(1'b0, 1'b1, 8'h0F);
    idle_steps(1'b1, 10);
    idle_steps(1'b0, 40);
    check("drop_level", {5'd0, fifo_level}, 8'd1);
    idle_steps(1'b1, 40);

    // Asynchronous reset 13 cycles into 8'h3C with two words queued.
    step(1'b0, 1'b1, 8'h3C);
    step(1'b0, 1'b1, 8'h11);
    step(1'b0, 1'b1, 8'h22);
    idle_steps(1'b1, 13);
    #2 reset = 0;
    #1;
    model_reset();
    check("arst_data_out", {7'd0, data_out},   8'd0);
    check("arst_busy",     {7'd0, busy},       8'd0);
    check("arst_level",    {5'd0, fifo_level}, 8'd0);
    check("arst_ready",    {7'd0, data_ready}, 8'd1);
    @(negedge clock_160);
    reset = 1;
    idle_steps(1'b1, 40);

    // Loopback sequence.
    step(1'b1, 1'b1, 8'hA5);
    step(1'b1, 1'b1, 8'h5A);
    step(1'b1, 1'b1, 8'hC3);
    idle_steps(1'b1, 110);

    // Random traffic with slowly toggling enable.
    en_r = 1'b1;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 24) == 0) en_r = ~en_r;
      step(en_r, 1'($urandom_range(0, 2) == 0), 8'($urandom));
    end
    idle_steps(1'b1, 200);
    check("lb_drained", 8'(lb_q.size()), 8'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ser_160.md
Name: ser_160

Overview:
- 160 MHz serializer. Accepts 8-bit words over a valid/ready handshake and buffers them in a small FIFO.
- Emits each word LSB first on a 1-bit line, holding each bit for OVERSAMPLE clocks (40 Mb/s at 4x).
- Feeds the downstream 160 MHz deserializer. That stage samples phase 3 of each bit and completes a word every 32 clocks.

Parameters:
- FIFO_DEPTH, 4, input word buffer depth (power of 2, ≥2).
- OVERSAMPLE, 4, clocks per serial bit (power of 2, ≥2).
- IDLE_WORD, 8'hBC, word sent when no data is pending (IDLE_PATTERN_EN builds only).

Ports:
- clock_160  input  1  160 MHz clock, all logic on rising edge.
- reset  input  1  asynchronous, active-low reset.
- enable  input  1  permits starting new words.
- data_in  input  8  parallel word.
- data_valid  input  1  data_in valid.
- data_ready  output  1  FIFO can accept; equals !full (from registered level).
- data_out  output  1  serial bit stream, registered.
- word_start  output  1  one-cycle pulse on first cycle of bit0 of each data word.
- busy  output  1  high while a word is on data_out.
- fifo_level  output  $clog2(FIFO_DEPTH+1)  words held in FIFO.

Behaviour:
- Reset (reset=0, async): FIFO emptied, fifo_level=0, data_ready=1, data_out=0, word_start=0, busy=0, state=IDLE, phase and bit counters=0. Reset mid-word aborts the word; no partial word resumes.
- Push: at an edge with data_valid && data_ready, the word is written at the tail.
- Push at full is never accepted, even if a pop occurs the same cycle.
- Push and pop in the same cycle leave fifo_level unchanged.
- States: IDLE, SHIFT.
- IDLE → SHIFT: at an edge with enable=1 and fifo_level>0:
  - pop the head into the 8-bit shift register;
  - data_out<=head[0], word_start<=1, busy<=1;
  - phase<=0, bit<=0.
- SHIFT: phase increments each clock. At phase=OVERSAMPLE-1:
  - phase wraps to 0 and bit increments;
  - data_out<=next bit (shift right).
- End of word: the last cycle of a word is bit=7, phase=OVERSAMPLE-1.
  - If enable=1 and fifo_level>0: pop the next word and load bit0 at that same edge. No gap; word_start pulses again.
  - Otherwise go to IDLE: data_out<=0, busy<=0.
- Frame length is exactly 8*OVERSAMPLE clocks (32 at default). Back-to-back words are contiguous.
- Latency: a word pushed into an empty FIFO in IDLE at edge T is popped at edge T+1. Bit0 is visible from T+1 for OVERSAMPLE cycles.
- enable deasserted mid-word: the current word completes fully, then the block enters IDLE. FIFO contents are retained.
- word_start is 0 in all other cycles.

Optional Feature:
- Macro: SER_IDLE_PATTERN_EN.
- Defined:
  - The serializer never idles after the first enable.
  - At every frame boundary it pops a data word if one is available, otherwise it transmits IDLE_WORD (LSB first, same timing).
  - word_start pulses only for data words; busy stays high.
  - Deasserting enable causes IDLE_WORD frames only, so frame alignment is always preserved.
- Undefined: behaviour exactly as above; data_out=0 in IDLE.

Test Plan:
- Single word: push 8'hA5 into an empty block, enable=1 → data_out = 1,0,1,0,0,1,0,1, each held 4 cycles starting the edge after the push. word_start high exactly 1 cycle. busy high 32 cycles, then data_out=0.
- Burst and backpressure: push 6 words 8'h01..8'h06 continuously with enable=0 → data_ready=0 once fifo_level=4, and only 01..04 are accepted. Then enable=1 → 128 contiguous cycles, 4 word_start pulses 32 cycles apart, no gap. data_ready returns to 1 on the first pop.
- Enable drop: deassert enable at cycle 10 of word 8'hFF with 8'h0F queued → 8'hFF completes all 32 cycles, then IDLE with fifo_level=1. Re-assert enable → 8'h0F is sent.
- Reset mid-word: assert reset at cycle 13 of 8'h3C with 2 words queued → data_out=0, busy=0, fifo_level=0, data_ready=1 immediately (asynchronously). No output after release until a new push.
- Loopback: drive data_out into the downstream deserializer, with its enable/count aligned to word_start → it recovers 8'hA5, 8'h5A, 8'hC3 in order.
- SER_IDLE_PATTERN_EN build: enable=1 with an empty FIFO → repeating 8'hBC frames with no word_start. Push 8'h77 mid-frame → 8'h77 starts exactly at the next 32-cycle boundary with a word_start pulse.
